// File: rtl/door_if_pkg.sv
// Shared door-count interface definitions: field order inside a door slot and the
// helper that locates a field on the packed system bus.
package door_if_pkg;

  localparam int NFIELDS = 4;
  localparam int F_A_IN  = 3;
  localparam int F_A_OUT = 2;
  localparam int F_B_IN  = 1;
  localparam int F_B_OUT = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SEND
  } door_state_e;

  // Bit position of field k of door d on a bus built from width-bit fields.
  function automatic int fld_lsb(input int width, input int d, input int k);
    return NFIELDS * width * d + width * k;
  endfunction

endpackage

// File: rtl/door_acc_cell.sv
// One door's four saturating event counters; clr reloads them with the pulses of the
// same cycle so nothing arriving during a launch is lost.
module door_acc_cell
  import door_if_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NFIELDS-1:0]       pulse,
  output logic [NFIELDS*WIDTH-1:0] cnt,
  output logic                     ovf,
  output logic                     at_thresh,
  output logic                     nonzero
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] THR     = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] THR_M1  = WIDTH'(THRESH - 1);

  logic [WIDTH-1:0]   cnt_q [NFIELDS];
  logic [WIDTH-1:0]   cnt_d [NFIELDS];
  logic               ovf_q, ovf_d;
  logic [NFIELDS-1:0] thr_hit, nz;

  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < NFIELDS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr) begin
        cnt_d[k] = WIDTH'(pulse[k]);
      end else if (pulse[k]) begin
        if (cnt_q[k] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[k] = cnt_q[k] + 1'b1;
      end
      // A field "reaches" the threshold in the cycle its THRESH-th pulse arrives,
      // so the frame launches with THRESH-1 and that pulse opens the next frame.
      thr_hit[k] = (cnt_q[k] >= THR) || (pulse[k] && (cnt_q[k] == THR_M1));
      nz[k]      = |cnt_q[k];
    end
    if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NFIELDS; k++) cnt_q[k] <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < NFIELDS; k++) cnt_q[k] <= cnt_d[k];
      ovf_q <= ovf_d;
    end
  end

  for (genvar gi = 0; gi < NFIELDS; gi++) begin : g_fld
    assign cnt[fld_lsb(WIDTH, 0, gi) +: WIDTH] = cnt_q[gi];
  end

  assign ovf       = ovf_q;
  assign at_thresh = |thr_hit;
  assign nonzero   = |nz;

endmodule

// File: rtl/door_event_packer.sv
// Door event source: per-door saturating counts packed into frames under valid/ready.
// Define FRAME_SEQ_EN to add the frame_seq output and its launch counter.
module door_event_packer
  import door_if_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int NDOORS = 3,
  parameter int PERIOD = 64,
  parameter int THRESH = 8,
  parameter int SEQW   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NDOORS-1:0]              ev_a_in,
  input  logic [NDOORS-1:0]              ev_a_out,
  input  logic [NDOORS-1:0]              ev_b_in,
  input  logic [NDOORS-1:0]              ev_b_out,
  input  logic                           flush,
  output logic                           sys_valid,
  input  logic                           sys_ready,
  output logic [NFIELDS*WIDTH*NDOORS-1:0] system,
  output logic                           sys_ovf
`ifdef FRAME_SEQ_EN
  ,
  output logic [SEQW-1:0]                frame_seq
`endif
);

  localparam int DW = NFIELDS * WIDTH;
  localparam int FW = DW * NDOORS;

  door_state_e state_q, state_d;

  logic [NDOORS-1:0][NFIELDS-1:0] cell_pulse;
  logic [FW-1:0]                  acc_flat;
  logic [NDOORS-1:0]              cell_ovf, cell_thr, cell_nz;
  logic                           any_nz, any_pulse, period_hit, trig, launch;
  logic [FW-1:0]                  frame_q, frame_d;
  logic                           frame_ovf_q, frame_ovf_d;

  for (genvar gi = 0; gi < NDOORS; gi++) begin : g_door
    assign cell_pulse[gi][F_A_IN]  = ev_a_in[gi];
    assign cell_pulse[gi][F_A_OUT] = ev_a_out[gi];
    assign cell_pulse[gi][F_B_IN]  = ev_b_in[gi];
    assign cell_pulse[gi][F_B_OUT] = ev_b_out[gi];

    door_acc_cell #(
      .WIDTH (WIDTH),
      .THRESH(THRESH)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (launch),
      .pulse    (cell_pulse[gi]),
      .cnt      (acc_flat[fld_lsb(WIDTH, gi, 0) +: DW]),
      .ovf      (cell_ovf[gi]),
      .at_thresh(cell_thr[gi]),
      .nonzero  (cell_nz[gi])
    );
  end

  if (PERIOD != 0) begin : g_timer
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
      timer_d = timer_q + 1'b1;
      if (launch || (state_q == ST_IDLE) || (timer_q == TW'(PERIOD - 1))) timer_d = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
    end

    assign period_hit = (timer_q == TW'(PERIOD - 1));
  end else begin : g_no_timer
    assign period_hit = 1'b0;
  end

  assign any_nz    = |cell_nz;
  assign any_pulse = |{ev_a_in, ev_a_out, ev_b_in, ev_b_out};
  assign trig      = any_nz && (period_hit || (|cell_thr) || flush);
  // A pending frame blocks launches until the consumer takes it.
  assign launch    = trig && ((state_q != ST_SEND) || sys_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_pulse) state_d = ST_ACCUM;
      ST_ACCUM: if (launch) state_d = ST_SEND;
      ST_SEND: begin
        if (sys_ready) begin
          if (launch)                      state_d = ST_SEND;
          else if (any_nz || any_pulse)    state_d = ST_ACCUM;
          else                             state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_d     = frame_q;
    frame_ovf_d = frame_ovf_q;
    if (launch) begin
      frame_d     = acc_flat;
      frame_ovf_d = |cell_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      frame_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      frame_ovf_q <= frame_ovf_d;
    end
  end

  assign sys_valid = (state_q == ST_SEND);
  assign system    = frame_q;
  assign sys_ovf   = frame_ovf_q;

`ifdef FRAME_SEQ_EN
  logic [SEQW-1:0] seq_cnt_q, seq_cnt_d, frame_seq_q, frame_seq_d;

  always_comb begin
    seq_cnt_d   = seq_cnt_q;
    frame_seq_d = frame_seq_q;
    if (launch) begin
      frame_seq_d = seq_cnt_q;
      seq_cnt_d   = seq_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt_q   <= '0;
      frame_seq_q <= '0;
    end else begin
      seq_cnt_q   <= seq_cnt_d;
      frame_seq_q <= frame_seq_d;
    end
  end

  assign frame_seq = frame_seq_q;
`endif

endmodule

// File: tb/tb_door_event_packer.sv
// Directed bench for door_event_packer: default instance plus a WIDTH=4 saturation instance.
module tb_door_event_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   ev_a_in, ev_a_out, ev_b_in, ev_b_out;
  logic         flush, sys_ready;
  logic         sys_valid, sys_ovf;
  logic [119:0] system;
`ifdef FRAME_SEQ_EN
  logic [7:0]   frame_seq;
`endif

  logic [2:0]   s_a_in, s_a_out, s_b_in, s_b_out;
  logic         s_flush, s_ready;
  logic         s_valid, s_ovf;
  logic [47:0]  s_system;
`ifdef FRAME_SEQ_EN
  logic [7:0]   s_frame_seq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  door_event_packer dut (
    .clk(clk), .rst(rst),
    .ev_a_in(ev_a_in), .ev_a_out(ev_a_out), .ev_b_in(ev_b_in), .ev_b_out(ev_b_out),
    .flush(flush), .sys_valid(sys_valid), .sys_ready(sys_ready),
    .system(system), .sys_ovf(sys_ovf)
`ifdef FRAME_SEQ_EN
    , .frame_seq(frame_seq)
`endif
  );

  door_event_packer #(.WIDTH(4), .NDOORS(3), .PERIOD(0), .THRESH(15), .SEQW(8)) dut_s (
    .clk(clk), .rst(rst),
    .ev_a_in(s_a_in), .ev_a_out(s_a_out), .ev_b_in(s_b_in), .ev_b_out(s_b_out),
    .flush(s_flush), .sys_valid(s_valid), .sys_ready(s_ready),
    .system(s_system), .sys_ovf(s_ovf)
`ifdef FRAME_SEQ_EN
    , .frame_seq(s_frame_seq)
`endif
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {ev_a_in, ev_a_out, ev_b_in, ev_b_out} = '0;
    {s_a_in, s_a_out, s_b_in, s_b_out} = '0;
    flush = 1'b0; sys_ready = 1'b1;
    s_flush = 1'b0; s_ready = 1'b0;
    tick; tick;
    rst = 1'b0;

    check_val("reset_valid", 128'(sys_valid), 128'h0);
    check_val("reset_system", 128'(system), 128'h0);
    check_val("reset_ovf", 128'(sys_ovf), 128'h0);

    // Single event: door0 a_in
    ev_a_in = 3'b001; tick;
    ev_a_in = 3'b000;
    check_val("single_no_early_valid", 128'(sys_valid), 128'h0);
    flush = 1'b1; tick;
    flush = 1'b0;
    check_val("single_valid", 128'(sys_valid), 128'h1);
    check_val("single_system", 128'(system), 128'h1 << 30);
    check_val("single_ovf", 128'(sys_ovf), 128'h0);
    tick;
    check_val("single_accepted", 128'(sys_valid), 128'h0);

    // Multi-door same cycle: door2 b_in (bit 90), door1 a_out (bit 60)
    ev_b_in = 3'b100; ev_a_out = 3'b010; tick;
    ev_b_in = 3'b000; ev_a_out = 3'b000;
    flush = 1'b1; tick;
    flush = 1'b0;
    check_val("multi_system", 128'(system), (128'h1 << 90) | (128'h1 << 60));
    tick;
    check_val("multi_accepted", 128'(sys_valid), 128'h0);

    // Backpressure
    sys_ready = 1'b0;
    ev_a_in = 3'b001; tick; tick;
    ev_a_in = 3'b000;
    flush = 1'b1; tick;
    flush = 1'b0;
    check_val("bp_f1_system", 128'(system), 128'h2 << 30);
    ev_a_in = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_val($sformatf("bp_hold_valid_%0d", i), 128'(sys_valid), 128'h1);
      check_val($sformatf("bp_hold_system_%0d", i), 128'(system), 128'h2 << 30);
    end
    ev_a_in = 3'b000;
    sys_ready = 1'b1; tick;
    check_val("bp_accept_no_relaunch", 128'(sys_valid), 128'h0);
    flush = 1'b1; tick;
    flush = 1'b0;
    check_val("bp_f2_system", 128'(system), 128'h5 << 30);
    tick;

    // Threshold: 8 consecutive door1 b_out pulses (bit 40)
    ev_b_out = 3'b010;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 6) check_val("thr_not_yet", 128'(sys_valid), 128'h0);
    end
    ev_b_out = 3'b000;
    check_val("thr_valid", 128'(sys_valid), 128'h1);
    check_val("thr_system", 128'(system), 128'h7 << 40);
    tick;
    check_val("thr_accepted", 128'(sys_valid), 128'h0);
    flush = 1'b1; tick;
    flush = 1'b0;
    check_val("thr_split_system", 128'(system), 128'h1 << 40);
    tick;

    // Saturation on the WIDTH=4 instance (door0 a_in at bit 12)
    s_a_in = 3'b001; tick;
    s_a_in = 3'b000;
    s_flush = 1'b1; tick;
    s_flush = 1'b0;
    check_val("sat_pre_system", 128'(s_system), 128'h1 << 12);
    s_a_in = 3'b001;
    for (int i = 0; i < 20; i++) tick;
    s_a_in = 3'b000;
    check_val("sat_hold_system", 128'(s_system), 128'h1 << 12);
    check_val("sat_hold_ovf", 128'(s_ovf), 128'h0);
    s_ready = 1'b1; tick;
    check_val("sat_relaunch_valid", 128'(s_valid), 128'h1);
    check_val("sat_system", 128'(s_system), 128'hF << 12);
    check_val("sat_ovf", 128'(s_ovf), 128'h1);
    tick;
    check_val("sat_accepted", 128'(s_valid), 128'h0);
    s_a_in = 3'b001; tick;
    s_a_in = 3'b000;
    s_flush = 1'b1; tick;
    s_flush = 1'b0;
    check_val("sat_next_system", 128'(s_system), 128'h1 << 12);
    check_val("sat_next_ovf", 128'(s_ovf), 128'h0);
    tick;

    // Reset mid-SEND; pulse during reset is dropped
    sys_ready = 1'b0;
    ev_a_in = 3'b001; tick;
    ev_a_in = 3'b000;
    flush = 1'b1; tick;
    flush = 1'b0;
    check_val("rst_pre_valid", 128'(sys_valid), 128'h1);
    rst = 1'b1; ev_a_in = 3'b001; tick;
    rst = 1'b0; ev_a_in = 3'b000;
    check_val("rst_valid", 128'(sys_valid), 128'h0);
    check_val("rst_system", 128'(system), 128'h0);
    sys_ready = 1'b1;
    flush = 1'b1; tick;
    flush = 1'b0;
    check_val("rst_pulse_dropped", 128'(sys_valid), 128'h0);

`ifdef FRAME_SEQ_EN
    for (int i = 0; i <= 256; i++) begin
      ev_a_in = 3'b001; tick;
      ev_a_in = 3'b000;
      flush = 1'b1; tick;
      flush = 1'b0;
      if (i == 0 || i == 1 || i == 255 || i == 256) begin
        check_val($sformatf("seq_valid_%0d", i), 128'(sys_valid), 128'h1);
        check_val($sformatf("seq_value_%0d", i), 128'(frame_seq), 128'(i % 256));
      end
      tick;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
